phyretrain_sb_arbiter: RTL

- Shares the single sideband (SB) transmit port between the PHYRETRAIN TX-side and RX-side sub-FSMs.
- Replaces per-FSM "is the other side sending" hold flags with one central grant/handshake sequencer.
- Latches each requester's message, presents exactly one message at a time to the SB encoder and runs the valid/busy handshake.
- Returns a one-cycle done pulse to the owning requester. A watchdog aborts transfers the SB never accepts.

---
 rtl/phyretrain_sb_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/phyretrain_sb_arbiter.sv
// phyretrain_sb_arbiter
// Shares the single sideband transmit port between the PHYRETRAIN TX-side
// and RX-side sub-FSMs. One central sequencer latches the winning request,
// runs the valid/busy handshake with the SB encoder, and returns a one-cycle
// done pulse to the owner. A watchdog aborts transfers the SB never accepts.
module phyretrain_sb_arbiter #(
   parameter int SB_MSG_WIDTH   = 4,
   parameter int ENC_WIDTH      = 3,
   parameter int ACCEPT_TIMEOUT = 1023
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_enable,
   input  logic                    i_tx_req,
   input  logic [SB_MSG_WIDTH-1:0] i_tx_msg,
   input  logic [ENC_WIDTH-1:0]    i_tx_enc,
   input  logic                    i_rx_req,
   input  logic [SB_MSG_WIDTH-1:0] i_rx_msg,
   input  logic [ENC_WIDTH-1:0]    i_rx_enc,
   input  logic                    i_sb_busy,
   output logic                    o_sb_valid,
   output logic [SB_MSG_WIDTH-1:0] o_sb_msg,
   output logic [ENC_WIDTH-1:0]    o_sb_enc,
   output logic                    o_sb_src,
   output logic                    o_tx_done,
   output logic                    o_rx_done,
   output logic                    o_timeout
);

   localparam logic [2:0] S_IDLE         = 3'd0;
   localparam logic [2:0] S_ISSUE        = 3'd1;
   localparam logic [2:0] S_WAIT_ACCEPT  = 3'd2;
   localparam logic [2:0] S_WAIT_RELEASE = 3'd3;
   localparam logic [2:0] S_DONE         = 3'd4;

   // The watchdog is compared before it increments, so the abort fires on the
   // WAIT_ACCEPT cycle in which the count would reach ACCEPT_TIMEOUT.
   localparam logic [15:0] WD_LIMIT = 16'(ACCEPT_TIMEOUT - 1);

   logic [2:0]  state;
   logic [15:0] wd_cnt;
   logic        busy_q;
   logic        prefer_rx;
   logic        tx_cand;
   logic        rx_cand;
   logic        grant_rx;

   // Request masking and winner selection; the done pulse doubles as the
   // one-cycle mask that stops the owner's stale level from re-issuing.
   always_comb begin
      tx_cand  = i_tx_req & ~o_tx_done;
      rx_cand  = i_rx_req & ~o_rx_done;
      grant_rx = rx_cand & (~tx_cand | prefer_rx);
   end

   // Registered copy of busy, used to find the busy falling edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         busy_q <= 1'b0;
      end else begin
         busy_q <= i_sb_busy;
      end
   end

   // Saturating acceptance watchdog, running only while waiting for busy.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wd_cnt <= 16'd0;
      end else if (!i_enable || state != S_WAIT_ACCEPT) begin
         wd_cnt <= 16'd0;
      end else if (wd_cnt != 16'hFFFF) begin
         wd_cnt <= wd_cnt + 16'd1;
      end
   end

   // Round-robin pointer: after a completed grant, prefer the other side.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         prefer_rx <= 1'b1;
      end else if (i_enable && state == S_DONE) begin
         prefer_rx <= ~o_sb_src;
      end
   end

   // Grant/handshake sequencer with registered outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= S_IDLE;
         o_sb_valid <= 1'b0;
         o_sb_msg   <= '0;
         o_sb_enc   <= '0;
         o_sb_src   <= 1'b0;
         o_tx_done  <= 1'b0;
         o_rx_done  <= 1'b0;
         o_timeout  <= 1'b0;
      end else begin
         o_tx_done <= 1'b0;
         o_rx_done <= 1'b0;
         o_timeout <= 1'b0;
         if (!i_enable) begin
            state      <= S_IDLE;
            o_sb_valid <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (tx_cand || rx_cand) begin
                     o_sb_msg   <= grant_rx ? i_rx_msg : i_tx_msg;
                     o_sb_enc   <= grant_rx ? i_rx_enc : i_tx_enc;
                     o_sb_src   <= grant_rx;
                     o_sb_valid <= 1'b1;
                     state      <= S_ISSUE;
                  end
               end
               S_ISSUE: begin
                  state <= S_WAIT_ACCEPT;
               end
               S_WAIT_ACCEPT: begin
                  if (i_sb_busy) begin
                     state <= S_WAIT_RELEASE;
                  end else if (wd_cnt >= WD_LIMIT) begin
                     o_sb_valid <= 1'b0;
                     o_timeout  <= 1'b1;
                     state      <= S_IDLE;
                  end
               end
               S_WAIT_RELEASE: begin
                  if (busy_q && !i_sb_busy) begin
                     o_sb_valid <= 1'b0;
                     state      <= S_DONE;
                  end
               end
               S_DONE: begin
                  o_tx_done <= ~o_sb_src;
                  o_rx_done <= o_sb_src;
                  state     <= S_IDLE;
               end
               default: begin
                  o_sb_valid <= 1'b0;
                  state      <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule
